// File: rtl/pattern_pkg.sv
// Shared defaults and types for the BRAM frame reader.
// Imported by bram_frame_reader and bram_read_skid_fifo.
package pattern_pkg;

    localparam int IMG_WIDTH_D  = 640;
    localparam int IMG_HEIGHT_D = 480;
    localparam int ADDR_WIDTH_D = 19;
    localparam int FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_read_skid_fifo.sv
// Four-entry skid buffer between the BRAM read pipe and the pixel stream.
// Flush empties it in one edge and takes priority over push/pop.
module bram_read_skid_fifo
    import pattern_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [2:0]       o_count
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [1:0]       r_wr;
    logic [1:0]       r_rd;
    logic [2:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop & (r_count != 3'd0);
    assign w_push = i_push & ((r_count != DEPTH) | w_pop);

    always_ff @(posedge clk) begin
        if (w_push & ~i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_count <= 3'd0;
        end else if (i_flush) begin
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 2'd1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    assign o_valid = (r_count != 3'd0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/bram_frame_reader.sv
// Streams an IMG_WIDTH x IMG_HEIGHT frame out of a synchronous BRAM.
// Define BRAM_FRAME_READER_COORDS_EN to add m_x/m_y beat coordinates.
module bram_frame_reader
    import pattern_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int DATA_WIDTH = 1,
    parameter int IMG_WIDTH  = IMG_WIDTH_D,
    parameter int IMG_HEIGHT = IMG_HEIGHT_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic [ADDR_WIDTH-1:0]     raddr,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_sof,
    output logic                      m_eol,
    output logic                      m_eof,
`ifdef BRAM_FRAME_READER_COORDS_EN
    output logic [cw(IMG_WIDTH)-1:0]  m_x,
    output logic [cw(IMG_HEIGHT)-1:0] m_y,
`endif
    output logic                      busy,
    output logic                      done
);

    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int XW = cw(IMG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] PENULT    = ADDR_WIDTH'(N - 2);
    localparam logic [XW-1:0]         LAST_COL  = XW'(IMG_WIDTH - 1);
`ifdef BRAM_FRAME_READER_COORDS_EN
    localparam int YW = cw(IMG_HEIGHT);
    localparam int FW = DATA_WIDTH + 3 + XW + YW;
`else
    localparam int FW = DATA_WIDTH + 3;
`endif

    reader_state_t         r_state;
    reader_state_t         w_next;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [XW-1:0]         r_col;
    logic                  r_v0;
    logic                  r_v1;
    logic                  r_done;
    pix_flags_t            w_f0;
    pix_flags_t            r_f1;
    pix_flags_t            w_out_f;
    logic                  w_load;
    logic                  w_issue;
    logic                  w_done_set;
    logic                  w_credit;
    logic                  w_at_last;
    logic                  w_hs;
    logic [2:0]            w_fifo_count;
    logic                  w_fifo_valid;
    logic [FW-1:0]         w_push_data;
    logic [FW-1:0]         w_pop_data;
    logic [DATA_WIDTH-1:0] w_out_data;
`ifdef BRAM_FRAME_READER_COORDS_EN
    logic [YW-1:0]         r_row;
    logic [XW-1:0]         r_x1;
    logic [YW-1:0]         r_y1;
    logic [XW-1:0]         w_out_x;
    logic [YW-1:0]         w_out_y;
`endif

    // Reads already issued (v0, v1) reserve a FIFO slot before data lands.
    assign w_credit  = ({1'b0, w_fifo_count} + {3'b000, r_v0}
                       + {3'b000, r_v1}) < 4'd4;
    assign w_at_last = (r_raddr == LAST_ADDR);
    assign w_hs      = w_fifo_valid & m_ready;

    assign w_f0.sof = (r_raddr == '0);
    assign w_f0.eol = (r_col == LAST_COL);
    assign w_f0.eof = w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_issue    = 1'b0;
        w_done_set = 1'b0;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next = ST_READ;
                        w_load = 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_at_last) begin
                        w_next = ST_DRAIN;
                    end else if (w_credit) begin
                        w_issue = 1'b1;
                        if (r_raddr == PENULT) begin
                            w_next = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_hs & w_out_f.eof) begin
                        w_next     = ST_IDLE;
                        w_done_set = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr <= '0;
            r_col   <= '0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_f1    <= '0;
            r_done  <= 1'b0;
`ifdef BRAM_FRAME_READER_COORDS_EN
            r_row   <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
`endif
        end else begin
            r_done <= w_done_set;
            if (abort) begin
                r_v0 <= 1'b0;
                r_v1 <= 1'b0;
            end else begin
                r_v1 <= r_v0;
                r_f1 <= w_f0;
`ifdef BRAM_FRAME_READER_COORDS_EN
                r_x1 <= r_col;
                r_y1 <= r_row;
`endif
                if (w_load) begin
                    r_raddr <= '0;
                    r_col   <= '0;
                    r_v0    <= 1'b1;
`ifdef BRAM_FRAME_READER_COORDS_EN
                    r_row   <= '0;
`endif
                end else if (w_issue) begin
                    r_raddr <= r_raddr + ADDR_WIDTH'(1);
                    r_v0    <= 1'b1;
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
`ifdef BRAM_FRAME_READER_COORDS_EN
                        r_row <= r_row + YW'(1);
`endif
                    end else begin
                        r_col <= r_col + XW'(1);
                    end
                end else begin
                    r_v0 <= 1'b0;
                end
            end
        end
    end

`ifdef BRAM_FRAME_READER_COORDS_EN
    assign w_push_data = {rdata, r_f1, r_x1, r_y1};
    assign {w_out_data, w_out_f, w_out_x, w_out_y} = w_pop_data;
`else
    assign w_push_data = {rdata, r_f1};
    assign {w_out_data, w_out_f} = w_pop_data;
`endif

    bram_read_skid_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_flush(abort),
        .i_push (r_v1),
        .i_data (w_push_data),
        .i_pop  (w_hs),
        .o_valid(w_fifo_valid),
        .o_data (w_pop_data),
        .o_count(w_fifo_count)
    );

    assign raddr   = r_raddr;
    assign m_valid = w_fifo_valid;
    assign m_data  = w_fifo_valid ? w_out_data : '0;
    assign m_sof   = w_fifo_valid & w_out_f.sof;
    assign m_eol   = w_fifo_valid & w_out_f.eol;
    assign m_eof   = w_fifo_valid & w_out_f.eof;
`ifdef BRAM_FRAME_READER_COORDS_EN
    assign m_x     = w_fifo_valid ? w_out_x : '0;
    assign m_y     = w_fifo_valid ? w_out_y : '0;
`endif
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule
